// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// Each accepted operation runs IDLE -> EXEC -> RESP and returns a registered result to its owner.
module alu_arbiter #(
    parameter int unsigned ALU_LENGTH = 4,
    parameter int unsigned DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ALU_LENGTH-1:0] req0_opcode,
    input  logic [DATA_W-1:0]     req0_left,
    input  logic [DATA_W-1:0]     req0_right,
    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic [DATA_W-1:0]     rsp0_result,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ALU_LENGTH-1:0] req1_opcode,
    input  logic [DATA_W-1:0]     req1_left,
    input  logic [DATA_W-1:0]     req1_right,
    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [DATA_W-1:0]     rsp1_result,

    output logic [ALU_LENGTH-1:0] alu_opcode,
    output logic [DATA_W-1:0]     alu_left,
    output logic [DATA_W-1:0]     alu_right,
    input  logic [DATA_W-1:0]     alu_result,

    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic                  w_any_req;
    logic                  w_grant;
    logic                  w_accept;
    logic                  w_rsp_done;
    logic [ALU_LENGTH-1:0] w_sel_opcode;
    logic [DATA_W-1:0]     w_sel_left;
    logic [DATA_W-1:0]     w_sel_right;

    logic                  r_last_grant;
    logic                  r_owner;
    logic                  r_busy;
    logic                  r_rsp0_valid;
    logic                  r_rsp1_valid;
    logic [DATA_W-1:0]     r_rsp0_result;
    logic [DATA_W-1:0]     r_rsp1_result;
    logic [ALU_LENGTH-1:0] r_alu_opcode;
    logic [DATA_W-1:0]     r_alu_left;
    logic [DATA_W-1:0]     r_alu_right;

    assign w_any_req = req0_valid || req1_valid;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, round-robin grant and handshake decode
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_accept    = 1'b0;
        w_rsp_done  = 1'b0;

        if (req0_valid && req1_valid) begin
            w_grant = ~r_last_grant;
        end else begin
            w_grant = req1_valid;
        end

        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                w_rsp_done = r_owner ? (r_rsp1_valid && rsp1_ready)
                                     : (r_rsp0_valid && rsp0_ready);
                if (w_rsp_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign req0_ready = w_accept && !w_grant;
    assign req1_ready = w_accept &&  w_grant;

    assign w_sel_opcode = w_grant ? req1_opcode : req0_opcode;
    assign w_sel_left   = w_grant ? req1_left   : req0_left;
    assign w_sel_right  = w_grant ? req1_right  : req0_right;

    // The ALU operand registers double as the latched request; they are only non-zero during EXEC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant  <= 1'b1;
            r_owner       <= 1'b0;
            r_busy        <= 1'b0;
            r_rsp0_valid  <= 1'b0;
            r_rsp1_valid  <= 1'b0;
            r_rsp0_result <= '0;
            r_rsp1_result <= '0;
            r_alu_opcode  <= '0;
            r_alu_left    <= '0;
            r_alu_right   <= '0;
        end else begin
            if (w_accept) begin
                r_owner      <= w_grant;
                r_last_grant <= w_grant;
                r_busy       <= 1'b1;
                r_alu_opcode <= w_sel_opcode;
                r_alu_left   <= w_sel_left;
                r_alu_right  <= w_sel_right;
            end

            if (r_state == S_EXEC) begin
                r_alu_opcode <= '0;
                r_alu_left   <= '0;
                r_alu_right  <= '0;
                if (r_owner) begin
                    r_rsp1_result <= alu_result;
                    r_rsp1_valid  <= 1'b1;
                end else begin
                    r_rsp0_result <= alu_result;
                    r_rsp0_valid  <= 1'b1;
                end
            end

            if (w_rsp_done) begin
                r_busy       <= 1'b0;
                r_rsp0_valid <= 1'b0;
                r_rsp1_valid <= 1'b0;
            end
        end
    end

    assign rsp0_valid  = r_rsp0_valid;
    assign rsp1_valid  = r_rsp1_valid;
    assign rsp0_result = r_rsp0_result;
    assign rsp1_result = r_rsp1_result;
    assign alu_opcode  = r_alu_opcode;
    assign alu_left    = r_alu_left;
    assign alu_right   = r_alu_right;
    assign busy        = r_busy;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU attached to the shared port.
// Vector table for single transactions plus hand-written arbitration, stall, reset and stream sequences.
module tb_alu_arbiter;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_EQ   = 4'd10;
    localparam int unsigned NVEC    = 13;

    logic        clk, rst;
    logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready;
    logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready;
    logic [3:0]  req0_opcode, req1_opcode, alu_opcode;
    logic [31:0] req0_left, req0_right, rsp0_result;
    logic [31:0] req1_left, req1_right, rsp1_result;
    logic [31:0] alu_left, alu_right, alu_result;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        port;
        logic [3:0]  op;
        logic [31:0] l;
        logic [31:0] r;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [NVEC];

    alu_arbiter #(.ALU_LENGTH(4), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
        .req0_left(req0_left), .req0_right(req0_right),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
        .req1_left(req1_left), .req1_right(req1_right),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .alu_opcode(alu_opcode), .alu_left(alu_left), .alu_right(alu_right),
        .alu_result(alu_result), .busy(busy)
    );

    // Stand-in for the shared combinational ALU
    function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_SLL:  return a << b[4:0];
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return 32'($signed(a) >>> b[4:0]);
            ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: return {31'd0, a < b};
            ALU_EQ:   return {31'd0, a == b};
            default:  return 32'd0;
        endcase
    endfunction

    assign alu_result = alu_model(alu_opcode, alu_left, alu_right);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic p, input logic v, input logic [3:0] op,
                           input logic [31:0] l, input logic [31:0] r);
        if (p) begin
            req1_valid = v; req1_opcode = op; req1_left = l; req1_right = r;
        end else begin
            req0_valid = v; req0_opcode = op; req0_left = l; req0_right = r;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    // One isolated transaction with the owner's rsp_ready already high
    task automatic run_one(input logic p, input logic [3:0] op, input logic [31:0] l,
                           input logic [31:0] r, input logic [31:0] exp);
        set_req(p, 1'b1, op, l, r);
        @(negedge clk);
        chk("accept_ready", p ? req1_ready : req0_ready, 32'd1);
        chk("other_ready",  p ? req0_ready : req1_ready, 32'd0);
        tick();
        set_req(p, 1'b0, 4'd0, 32'd0, 32'd0);
        @(negedge clk);
        chk("exec_opcode", {28'd0, alu_opcode}, {28'd0, op});
        chk("exec_left",   alu_left,  l);
        chk("exec_right",  alu_right, r);
        chk("exec_busy",   busy, 32'd1);
        tick();
        @(negedge clk);
        chk("rsp_valid",       p ? rsp1_valid : rsp0_valid, 32'd1);
        chk("rsp_result",      p ? rsp1_result : rsp0_result, exp);
        chk("rsp_other_valid", p ? rsp0_valid : rsp1_valid, 32'd0);
        chk("resp_alu_idle",   {28'd0, alu_opcode}, 32'd0);
        tick();
        @(negedge clk);
        chk("done_busy",  busy, 32'd0);
        chk("done_valid", p ? rsp1_valid : rsp0_valid, 32'd0);
        tick();
    endtask

    initial begin
        logic        owner;
        logic        adv, adv_port;
        logic        q_owner [$];
        logic [31:0] q_exp   [$];
        int          idx0, idx1, rsp_cnt, last_acc, prev_owner;
        logic [31:0] e;

        rst = 1'b1;
        req0_valid = 1'b0; req0_opcode = '0; req0_left = '0; req0_right = '0;
        req1_valid = 1'b0; req1_opcode = '0; req1_left = '0; req1_right = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;

        vecs[0]  = '{1'b0, ALU_ADD,  32'd5,          32'd7,          32'd12};
        vecs[1]  = '{1'b1, ALU_SUB,  32'd3,          32'd5,          32'hFFFF_FFFE};
        vecs[2]  = '{1'b1, ALU_EQ,   32'd9,          32'd9,          32'd1};
        vecs[3]  = '{1'b0, ALU_EQ,   32'd9,          32'd8,          32'd0};
        vecs[4]  = '{1'b0, ALU_SRA,  32'h8000_0000,  32'd4,          32'hF800_0000};
        vecs[5]  = '{1'b1, ALU_SRL,  32'h8000_0000,  32'd4,          32'h0800_0000};
        vecs[6]  = '{1'b0, ALU_OR,   32'h0000_00F0,  32'h0000_000F,  32'h0000_00FF};
        vecs[7]  = '{1'b1, ALU_AND,  32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000};
        vecs[8]  = '{1'b0, ALU_XOR,  32'hFFFF_0000,  32'hFFFF_FFFF,  32'h0000_FFFF};
        vecs[9]  = '{1'b1, ALU_SLL,  32'd1,          32'd31,         32'h8000_0000};
        vecs[10] = '{1'b0, ALU_SLT,  32'hFFFF_FFFF,  32'd1,          32'd1};
        vecs[11] = '{1'b1, ALU_SLTU, 32'hFFFF_FFFF,  32'd1,          32'd0};
        vecs[12] = '{1'b0, 4'hF,     32'd1,          32'd1,          32'd0};

        do_reset();
        @(negedge clk);
        chk("rst_busy",        busy, 32'd0);
        chk("rst_rsp0_valid",  rsp0_valid, 32'd0);
        chk("rst_rsp1_valid",  rsp1_valid, 32'd0);
        chk("rst_rsp0_result", rsp0_result, 32'd0);
        chk("rst_rsp1_result", rsp1_result, 32'd0);
        chk("rst_alu_opcode",  {28'd0, alu_opcode}, 32'd0);
        chk("rst_alu_left",    alu_left, 32'd0);
        chk("rst_alu_right",   alu_right, 32'd0);
        chk("rst_idle_ready",  {31'd0, req0_ready | req1_ready}, 32'd0);
        tick();

        for (int i = 0; i < int'(NVEC); i++) begin
            run_one(vecs[i].port, vecs[i].op, vecs[i].l, vecs[i].r, vecs[i].exp);
        end

        // Simultaneous requests from reset: port 0 wins, port 1 waits
        do_reset();
        set_req(1'b0, 1'b1, ALU_SUB, 32'd3, 32'd5);
        set_req(1'b1, 1'b1, ALU_EQ,  32'd9, 32'd9);
        @(negedge clk);
        chk("rr1_ready0", req0_ready, 32'd1);
        chk("rr1_ready1", req1_ready, 32'd0);
        tick();
        set_req(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        @(negedge clk);
        chk("rr1_exec_ready1", req1_ready, 32'd0);
        chk("rr1_exec_opcode", {28'd0, alu_opcode}, {28'd0, ALU_SUB});
        tick();
        @(negedge clk);
        chk("rr1_rsp0_valid",  rsp0_valid, 32'd1);
        chk("rr1_rsp0_result", rsp0_result, 32'hFFFF_FFFE);
        chk("rr1_resp_ready1", req1_ready, 32'd0);
        tick();
        @(negedge clk);
        chk("rr1_ready1_late", req1_ready, 32'd1);
        tick();
        set_req(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
        @(negedge clk);
        chk("rr1_exec2_opcode", {28'd0, alu_opcode}, {28'd0, ALU_EQ});
        tick();
        @(negedge clk);
        chk("rr1_rsp1_valid",  rsp1_valid, 32'd1);
        chk("rr1_rsp1_result", rsp1_result, 32'd1);
        chk("rr1_rsp0_quiet",  rsp0_valid, 32'd0);
        tick();

        // After a port 0 grant, a simultaneous pair goes to port 1 first
        run_one(1'b0, ALU_ADD, 32'd1, 32'd2, 32'd3);
        set_req(1'b0, 1'b1, ALU_ADD, 32'd4,  32'd4);
        set_req(1'b1, 1'b1, ALU_SUB, 32'd10, 32'd3);
        @(negedge clk);
        chk("rr2_ready1", req1_ready, 32'd1);
        chk("rr2_ready0", req0_ready, 32'd0);
        tick();
        set_req(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
        tick();
        @(negedge clk);
        chk("rr2_rsp1_result", rsp1_result, 32'd7);
        tick();
        @(negedge clk);
        chk("rr2_ready0_late", req0_ready, 32'd1);
        tick();
        set_req(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        tick();
        @(negedge clk);
        chk("rr2_rsp0_valid",  rsp0_valid, 32'd1);
        chk("rr2_rsp0_result", rsp0_result, 32'd8);
        tick();

        // Owner withholds rsp1_ready for 10 cycles; port 0 must stall
        rsp1_ready = 1'b0;
        set_req(1'b1, 1'b1, ALU_SRA, 32'h8000_0000, 32'd4);
        @(negedge clk);
        chk("stall_accept1", req1_ready, 32'd1);
        tick();
        set_req(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
        set_req(1'b0, 1'b1, ALU_ADD, 32'd1, 32'd1);
        @(negedge clk);
        chk("stall_exec_ready0", req0_ready, 32'd0);
        tick();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_rsp1_valid",  rsp1_valid, 32'd1);
            chk("stall_rsp1_result", rsp1_result, 32'hF800_0000);
            chk("stall_ready0",      req0_ready, 32'd0);
            tick();
        end
        rsp1_ready = 1'b1;
        @(negedge clk);
        chk("stall_hs_valid",  rsp1_valid, 32'd1);
        chk("stall_hs_ready0", req0_ready, 32'd0);
        tick();
        @(negedge clk);
        chk("stall_rel_valid",  rsp1_valid, 32'd0);
        chk("stall_rel_result", rsp1_result, 32'hF800_0000);
        chk("stall_rel_ready0", req0_ready, 32'd1);
        tick();
        set_req(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        tick();
        @(negedge clk);
        chk("stall_next_rsp0", rsp0_result, 32'd2);
        tick();

        // Asynchronous reset in the middle of EXEC drops the operation
        set_req(1'b0, 1'b1, ALU_OR, 32'h0000_00F0, 32'h0000_000F);
        @(negedge clk);
        chk("arst_accept", req0_ready, 32'd1);
        tick();
        set_req(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        #2;
        chk("arst_pre_opcode", {28'd0, alu_opcode}, {28'd0, ALU_OR});
        rst = 1'b1;
        #1;
        chk("arst_alu_opcode", {28'd0, alu_opcode}, 32'd0);
        chk("arst_alu_left",   alu_left, 32'd0);
        chk("arst_alu_right",  alu_right, 32'd0);
        chk("arst_busy",       busy, 32'd0);
        chk("arst_rsp0_valid", rsp0_valid, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("arst_no_rsp", rsp0_valid, 32'd0);
            chk("arst_idle",   busy, 32'd0);
            tick();
        end
        run_one(1'b0, ALU_ADD, 32'd5, 32'd7, 32'd12);

        // Both ports always valid: 8 alternating ops, exact 3-cycle issue interval
        idx0 = 0; idx1 = 0; rsp_cnt = 0; last_acc = -1; prev_owner = -1;
        set_req(1'b0, 1'b1, ALU_ADD, 32'd1,    32'd100);
        set_req(1'b1, 1'b1, ALU_SUB, 32'd1000, 32'd0);
        for (int cyc = 0; cyc < 60 && rsp_cnt < 8; cyc++) begin
            adv = 1'b0;
            adv_port = 1'b0;
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                owner = req1_ready;
                chk("stream_one_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
                if (last_acc >= 0) chk("stream_ii", 32'(cyc - last_acc), 32'd3);
                if (prev_owner >= 0 && req0_valid && req1_valid)
                    chk("stream_rr", {31'd0, owner}, {31'd0, ~prev_owner[0]});
                e = owner ? 32'(1000 - idx1) : 32'(idx0 + 101);
                q_owner.push_back(owner);
                q_exp.push_back(e);
                last_acc   = cyc;
                prev_owner = int'(owner);
                adv        = 1'b1;
                adv_port   = owner;
            end
            if (rsp0_valid || rsp1_valid) begin
                chk("stream_rsp_onehot", {31'd0, rsp0_valid & rsp1_valid}, 32'd0);
                if (q_owner.size() == 0) begin
                    chk("stream_unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    owner = q_owner.pop_front();
                    e     = q_exp.pop_front();
                    chk("stream_route",  {31'd0, rsp1_valid}, {31'd0, owner});
                    chk("stream_result", owner ? rsp1_result : rsp0_result, e);
                end
                rsp_cnt++;
            end
            tick();
            if (adv) begin
                if (adv_port) begin
                    idx1++;
                    if (idx1 == 4) set_req(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
                    else           set_req(1'b1, 1'b1, ALU_SUB, 32'd1000, 32'(idx1));
                end else begin
                    idx0++;
                    if (idx0 == 4) set_req(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
                    else           set_req(1'b0, 1'b1, ALU_ADD, 32'(idx0 + 1), 32'd100);
                end
            end
        end
        chk("stream_count", 32'(rsp_cnt), 32'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
